// File: rtl/fsm_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_bist_pkg
// Description : Shared types, constants and LFSR/MISR step function for the
//               BIST sequencer of the 4-bit Moore test-target FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_bist_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5,
    ABORT   = 3'd6
  } bist_state_e;

  // Feedback taps at bits 15, 13, 12 and 10
  localparam logic [15:0] POLY_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One shift of the 16-bit Fibonacci register with a 4-bit parallel input
  // folded into the low nibble (zero input gives a plain LFSR step).
  function automatic logic [15:0] lfsr16_step(input logic [15:0] cur,
                                              input logic [3:0]  din);
    return {cur[14:0], ^(cur & POLY_TAPS)} ^ {12'h000, din};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [15:0] effective_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? DEFAULT_SEED : seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr16
// Description : 16-bit Fibonacci shift register with synchronous load and a
//               4-bit parallel input. Used both as pattern LFSR (data_in = 0)
//               and as signature MISR (load_val = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr16
  import fsm_bist_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift_en,
  input  logic [3:0]  data_in,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Load has priority over shift; otherwise the register holds
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = lfsr16_step(q_q, data_in);
    end
  end

  // Register with asynchronous reset to the configured value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/fsm_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fsm_bist_ctrl
// Description : BIST sequencer for the 4-bit Moore test target. Resets the
//               target, applies NUM_PATTERNS LFSR stimuli, compacts the
//               target state into a MISR and compares against GOLDEN_SIG.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_bist_ctrl
  import fsm_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 64,
  parameter int unsigned CNT_W        = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bist_req_i,
  input  logic        bist_abort_i,
  input  logic [3:0]  state_i,
  output logic [3:0]  sig_o,
  output logic        tmode_o,
  output logic        tmode_clk_en_o,
  output logic        start_bist_o,
  output logic        rst_state_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] signature_o
);

  localparam logic [15:0]      SEED_EFF = effective_seed(LFSR_SEED);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sig_q, sig_d;
  logic             tmode_q, tmode_d;
  logic             clk_en_q, clk_en_d;
  logic             start_q, start_d;
  logic             rst_state_q, rst_state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [15:0]      lfsr_q;
  logic [15:0]      misr_q;
  logic [15:0]      lfsr_nxt;
  logic             lfsr_load;
  logic             lfsr_shift;
  logic             misr_clear;
  logic             misr_shift;

  // Datapath controls follow the current state
  assign lfsr_load  = (state_q == INIT);
  assign lfsr_shift = (state_q == RUN);
  assign misr_clear = (state_q == INIT);
  assign misr_shift = (state_q == RUN) || (state_q == FLUSH);

  bist_lfsr16 #(
    .RESET_VAL (SEED_EFF)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (SEED_EFF),
    .shift_en (lfsr_shift),
    .data_in  (4'h0),
    .q        (lfsr_q)
  );

  bist_lfsr16 #(
    .RESET_VAL (16'h0000)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_clear),
    .load_val (16'h0000),
    .shift_en (misr_shift),
    .data_in  (state_i),
    .q        (misr_q)
  );

  // Next state and pattern counter; abort outranks a request everywhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bist_abort_i) begin
          state_d = IDLE;
        end else if (bist_req_i) begin
          state_d = INIT;
        end
      end
      INIT: begin
        cnt_d   = '0;
        state_d = bist_abort_i ? ABORT : RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bist_abort_i) begin
          state_d = ABORT;
        end else if (cnt_q == LAST_CNT) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = bist_abort_i ? ABORT : COMPARE;
      COMPARE: state_d = bist_abort_i ? ABORT : DONE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register with it
  always_comb begin
    lfsr_nxt = lfsr_q;
    if (lfsr_load) begin
      lfsr_nxt = SEED_EFF;
    end else if (lfsr_shift) begin
      lfsr_nxt = lfsr16_step(lfsr_q, 4'h0);
    end

    tmode_d     = state_d inside {INIT, RUN, FLUSH, COMPARE, ABORT};
    clk_en_d    = state_d inside {INIT, RUN, ABORT};
    start_d     = (state_d == INIT);
    rst_state_d = (state_d == ABORT);
    busy_d      = state_d inside {INIT, RUN, FLUSH, COMPARE};
    done_d      = (state_d == DONE);
    sig_d       = (state_d == RUN) ? lfsr_nxt[3:0] : 4'h0;

    // The verdict is captured leaving COMPARE and held only while in DONE
    pass_d = 1'b0;
    if (state_d == DONE) begin
      pass_d = (state_q == COMPARE) ? (misr_q == GOLDEN_SIG) : pass_q;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sig_q       <= 4'h0;
      tmode_q     <= 1'b0;
      clk_en_q    <= 1'b0;
      start_q     <= 1'b0;
      rst_state_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      tmode_q     <= tmode_d;
      clk_en_q    <= clk_en_d;
      start_q     <= start_d;
      rst_state_q <= rst_state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign sig_o          = sig_q;
  assign tmode_o        = tmode_q;
  assign tmode_clk_en_o = clk_en_q;
  assign start_bist_o   = start_q;
  assign rst_state_o    = rst_state_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign signature_o    = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_bist_ctrl
// Description : Scoreboard bench for fsm_bist_ctrl. Four sequencers share the
//               request/abort inputs: NUM_PATTERNS=4 with matching golden,
//               NUM_PATTERNS=4 with golden off by one bit, NUM_PATTERNS=1,
//               and NUM_PATTERNS=24. Each drives its own accumulator target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_bist_ctrl;

  localparam int NI     = 4;
  localparam int LONG_N = 24;

  typedef struct packed {
    logic        is_abort;
    logic        pass;
    logic [15:0] sig;
    logic [7:0]  blen;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bist_req;
  logic        bist_abort;

  logic [3:0]  sig_w    [NI];
  logic        tmode_w  [NI];
  logic        clken_w  [NI];
  logic        start_w  [NI];
  logic        rst_st_w [NI];
  logic        busy_w   [NI];
  logic        done_w   [NI];
  logic        pass_w   [NI];
  logic [15:0] sign_w   [NI];

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q [NI][$];

  always #5 clk = ~clk;

  function automatic int np_of(input int i);
    case (i)
      0, 1:    return 4;
      2:       return 1;
      default: return LONG_N;
    endcase
  endfunction

  function automatic logic [15:0] gold_of(input int i);
    case (i)
      0:       return 16'h0004;
      1:       return 16'h0005;
      2:       return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference arithmetic: Fibonacci shift with taps 15,13,12,10
  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [3:0] d);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb} ^ {12'h000, d};
  endfunction

  function automatic logic [3:0] lfsr_nib(input int idx);
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < idx; k++) l = ref_shift(l, 4'h0);
    return l[3:0];
  endfunction

  // Target model: accumulator t += stimulus; MISR sees t before each update
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] l, m;
    logic [3:0]  t;
    l = 16'hACE1; m = 16'h0000; t = 4'h0;
    for (int k = 0; k < n; k++) begin
      m = ref_shift(m, t);
      t = t + l[3:0];
      l = ref_shift(l, 4'h0);
    end
    return ref_shift(m, t);
  endfunction

  // Hand-derived signatures: N=4 samples 0,1,4,B,A -> 0004; N=1 samples 0,1 -> 0001
  function automatic logic [15:0] esig(input int i);
    if (i < 2)  return 16'h0004;
    if (i == 2) return 16'h0001;
    return model_sig(LONG_N);
  endfunction

  function automatic logic epass(input int i);
    case (i)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (model_sig(LONG_N) == 16'h0000);
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0] tgt;

    fsm_bist_ctrl #(
      .NUM_PATTERNS (np_of(g)),
      .CNT_W        (16),
      .LFSR_SEED    (16'hACE1),
      .GOLDEN_SIG   (gold_of(g))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bist_req_i     (bist_req),
      .bist_abort_i   (bist_abort),
      .state_i        (tgt),
      .sig_o          (sig_w[g]),
      .tmode_o        (tmode_w[g]),
      .tmode_clk_en_o (clken_w[g]),
      .start_bist_o   (start_w[g]),
      .rst_state_o    (rst_st_w[g]),
      .busy_o         (busy_w[g]),
      .done_o         (done_w[g]),
      .pass_o         (pass_w[g]),
      .signature_o    (sign_w[g])
    );

    // 4-bit Moore target: synchronous resets, advances only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          tgt <= 4'h0;
      else if (start_w[g] || rst_st_w[g])  tgt <= 4'h0;
      else if (clken_w[g])                 tgt <= tgt + sig_w[g];
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, inst, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NI; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic push_done();
    ev_t ev;
    for (int i = 0; i < NI; i++) begin
      ev.is_abort = 1'b0;
      ev.pass     = epass(i);
      ev.sig      = esig(i);
      ev.blen     = 8'(np_of(i) + 3);
      exp_q[i].push_back(ev);
    end
  endtask

  task automatic push_abort();
    ev_t ev;
    for (int i = 0; i < NI; i++) begin
      ev = '0;
      ev.is_abort = 1'b1;
      exp_q[i].push_back(ev);
    end
  endtask

  task automatic pulse(input logic r, input logic a);
    @(negedge clk);
    bist_req = r; bist_abort = a;
    @(negedge clk);
    bist_req = 1'b0; bist_abort = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int left = bound;
    while (pending() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    n_checks++;
    if (pending() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events outstanding, want 0", pending());
      for (int i = 0; i < NI; i++) exp_q[i].delete();
    end
  endtask

  // Monitor: per-cycle output rules, plus scoreboard pops on done/abort events
  initial begin : monitor
    int   run_idx [NI];
    int   blen    [NI];
    int   starts  [NI];
    int   rwid    [NI];
    logic done_p  [NI];
    logic rst_p   [NI];
    logic is_run;
    ev_t  ev;
    for (int i = 0; i < NI; i++) begin
      run_idx[i] = 0; blen[i] = 0; starts[i] = 0; rwid[i] = 0;
      done_p[i] = 1'b0; rst_p[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          run_idx[i] = 0; blen[i] = 0; starts[i] = 0; rwid[i] = 0;
          done_p[i] = 1'b0; rst_p[i] = 1'b0;
          continue;
        end
        is_run = clken_w[i] && !start_w[i] && !rst_st_w[i];
        if (start_w[i]) begin
          starts[i]++;
          run_idx[i] = 0;
        end
        if (is_run) begin
          chk("sig_o run", i, 32'(sig_w[i]), 32'(lfsr_nib(run_idx[i])));
          run_idx[i]++;
        end else begin
          chk("sig_o outside run", i, 32'(sig_w[i]), 32'h0);
        end
        chk("tmode_o", i, 32'(tmode_w[i]), 32'(busy_w[i] | rst_st_w[i]));
        chk("pass_o without done_o", i, 32'(pass_w[i] & ~done_w[i]), 32'h0);
        if (busy_w[i])   blen[i]++;
        if (rst_st_w[i]) rwid[i]++;
        if (!rst_st_w[i] && rst_p[i]) begin
          chk("rst_state_o width", i, 32'(rwid[i]), 32'd1);
          rwid[i] = 0;
        end
        if (done_w[i] && !done_p[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done[%0d]: got done event, want none", i);
          end else begin
            ev = exp_q[i].pop_front();
            chk("event kind (done)", i, 32'(ev.is_abort), 32'h0);
            chk("pass_o", i, 32'(pass_w[i]), 32'(ev.pass));
            chk("signature_o", i, 32'(sign_w[i]), 32'(ev.sig));
            chk("busy length", i, 32'(blen[i]), 32'(ev.blen));
            chk("start_bist cycles", i, 32'(starts[i]), 32'd1);
          end
          blen[i] = 0; starts[i] = 0;
        end
        if (rst_st_w[i] && !rst_p[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_abort[%0d]: got rst_state event, want none", i);
          end else begin
            ev = exp_q[i].pop_front();
            chk("event kind (abort)", i, 32'(ev.is_abort), 32'h1);
            chk("start_bist before abort", i, 32'(starts[i]), 32'd1);
          end
          blen[i] = 0; starts[i] = 0;
        end
        done_p[i] = done_w[i];
        rst_p[i]  = rst_st_w[i];
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; bist_req = 1'b0; bist_abort = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("reset outputs", i, 32'({sig_w[i], tmode_w[i], clken_w[i], start_w[i], rst_st_w[i],
                                   busy_w[i], done_w[i], pass_w[i], sign_w[i]}), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Full run on all four sequencers
    push_done();
    pulse(1'b1, 1'b0);
    wait_drain(80);
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("done_o held", i, 32'(done_w[i]), 32'h1);

    // Abort sampled at the end of the second RUN cycle
    push_abort();
    @(negedge clk); bist_req = 1'b1;
    @(negedge clk); bist_req = 1'b0;
    @(negedge clk);
    @(negedge clk); bist_abort = 1'b1;
    @(negedge clk); bist_abort = 1'b0;
    wait_drain(10);
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("idle after abort", i, 32'({done_w[i], busy_w[i], tmode_w[i], pass_w[i]}), 32'h0);

    // Re-request after abort
    push_done();
    pulse(1'b1, 1'b0);
    wait_drain(80);

    // Second request while busy must not lengthen or repeat the run
    push_done();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    wait_drain(80);
    repeat (40) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("no rerun after busy request", i, 32'({busy_w[i], done_w[i]}), 32'h1);

    // Request and abort together in DONE: back to IDLE, no INIT
    pulse(1'b1, 1'b1);
    for (int i = 0; i < NI; i++)
      chk("req+abort in DONE", i, 32'({done_w[i], busy_w[i], start_w[i], tmode_w[i]}), 32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("stays idle", i, 32'({done_w[i], busy_w[i], start_w[i], tmode_w[i]}), 32'h0);

    // Asynchronous reset in the middle of a run
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      chk("async reset mid-run", i, 32'({tmode_w[i], busy_w[i], clken_w[i], sig_w[i], sign_w[i]}), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Recovery run after reset
    push_done();
    pulse(1'b1, 1'b0);
    wait_drain(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
